// File: rtl/atari_cpu_scheduler.sv
// atari_cpu_scheduler
// Clock-enable generator for the 2600 core. It divides the color clock into
// CPU/RIOT ticks and tracks the horizontal position. It holds the 6507 in RDY=0
// after a WSYNC write until the scanline ends. It stretches the pending tick
// while external program memory reports busy.
//
// Ports:
//   clk           color clock (single domain)
//   rst           synchronous active-high reset
//   mem_busy      external memory not ready; defers the pending tick
//   wsync_wr      CPU write to TIA WSYNC; only honoured on a cpu_ce cycle
//   cpu_ce        6507 clock enable pulse (tick gated by rdy)
//   riot_ce       RIOT clock enable pulse (keeps running through WSYNC halts)
//   rdy           6507 RDY, low while halted by WSYNC
//   hpos          color-clock position within the line, 0..LINE_CLOCKS-1
//   line_start    high while hpos==0
//   stall_cycles  saturating count of cycles spent waiting on memory
module atari_cpu_scheduler #(
  parameter int LINE_CLOCKS = 228,
  parameter int CPU_DIV     = 3,
  parameter int STALL_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_busy,
  input  logic               wsync_wr,
  output logic               cpu_ce,
  output logic               riot_ce,
  output logic               rdy,
  output logic [7:0]         hpos,
  output logic               line_start,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int              PH_W      = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CPU_DIV - 1);
  localparam logic [7:0]      HPOS_LAST = 8'(LINE_CLOCKS - 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [PH_W-1:0] phase;
  logic [0:0]      state;
  logic            at_tick_phase;
  logic            tick;
  logic            stall;
  logic            line_end;

  assign at_tick_phase = (phase == PH_LAST);
  assign tick          = at_tick_phase && !mem_busy;
  // A stalled cycle is one where the tick is due but memory holds it off.
  assign stall         = at_tick_phase && mem_busy;
  assign line_end      = (hpos == HPOS_LAST);

  assign rdy        = (state == ST_RUN);
  assign riot_ce    = tick;
  assign cpu_ce     = tick && rdy;
  assign line_start = (hpos == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos         <= '0;
      phase        <= '0;
      state        <= ST_RUN;
      stall_cycles <= '0;
    end else begin
      // The beam position never stalls; only the CPU/RIOT phase does.
      hpos <= line_end ? 8'd0 : hpos + 8'd1;

      // Phase holds at the last step while memory is busy, so the tick is
      // deferred, not dropped, and later ticks shift by the stall length.
      if (!at_tick_phase)
        phase <= phase + 1'b1;
      else if (!mem_busy)
        phase <= '0;

      if (stall && (stall_cycles != {STALL_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;

      case (state)
        // A WSYNC on the last clock of a line halts until the end of the next
        // line. cpu_ce can only be high in RUN, so the set always takes
        // priority over the release.
        ST_RUN:  if (cpu_ce && wsync_wr) state <= ST_HALT;
        ST_HALT: if (line_end)           state <= ST_RUN;
        default:                         state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_atari_cpu_scheduler.sv
// Self-checking bench for atari_cpu_scheduler. A table of per-cycle vectors
// covers reset, the first ticks and a short stall. Hand-written sequences then
// cover cadence, WSYNC, the line-end corner case, long stalls, saturation
// (second instance with STALL_W=4) and reset during a halt.
module tb_atari_cpu_scheduler;

  logic        clk = 1'b0;
  logic        rst, mem_busy, wsync_wr;
  logic        cpu_ce, riot_ce, rdy, line_start;
  logic [7:0]  hpos;
  logic [15:0] stall_cycles;
  logic        cpu_ce2, riot_ce2, rdy2, line_start2;
  logic [7:0]  hpos2;
  logic [3:0]  stall_cycles2;

  always #5 clk = ~clk;

  atari_cpu_scheduler dut (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .wsync_wr(wsync_wr),
    .cpu_ce(cpu_ce), .riot_ce(riot_ce), .rdy(rdy), .hpos(hpos),
    .line_start(line_start), .stall_cycles(stall_cycles)
  );

  atari_cpu_scheduler #(.STALL_W(4)) dut_sat (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .wsync_wr(wsync_wr),
    .cpu_ce(cpu_ce2), .riot_ce(riot_ce2), .rdy(rdy2), .hpos(hpos2),
    .line_start(line_start2), .stall_cycles(stall_cycles2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int k;
  int errs;

  typedef struct {
    logic        rst, busy, ws;
    logic [7:0]  hpos;
    logic        cpu, riot, rdy, ls;
    logic [15:0] stall;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Leaves us 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_to(input int target);
    while (k < target) begin
      step();
      k++;
    end
  endtask

  // On return the DUT is in reset state with rst already low; the next edge
  // is cycle 0, so k tracks hpos until a stall or wrap.
  task automatic do_reset();
    rst = 1'b1; mem_busy = 1'b0; wsync_wr = 1'b0;
    step();
    step();
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    logic exp_t;
    int   ncpu, nls;

    //           rst busy ws  hpos cpu riot rdy ls stall
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 8'd2,  1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 8'd4,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'd5,  1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'd6,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'd8,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 8'd9,  1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'd11, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'd12, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'd13, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};

    rst = 1'b1; mem_busy = 1'b0; wsync_wr = 1'b0;
    step();
    step();

    // ---- table vectors ----
    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; mem_busy = vt[i].busy; wsync_wr = vt[i].ws;
      #2;
      check($sformatf("vec%0d_hpos", i),  hpos,         vt[i].hpos);
      check($sformatf("vec%0d_cpu", i),   cpu_ce,       vt[i].cpu);
      check($sformatf("vec%0d_riot", i),  riot_ce,      vt[i].riot);
      check($sformatf("vec%0d_rdy", i),   rdy,          vt[i].rdy);
      check($sformatf("vec%0d_ls", i),    line_start,   vt[i].ls);
      check($sformatf("vec%0d_stall", i), stall_cycles, vt[i].stall);
      step();
    end

    // ---- cadence over two lines ----
    do_reset();
    errs = 0; ncpu = 0; nls = 0;
    for (int c = 0; c < 456; c++) begin
      #2;
      exp_t = (c % 3 == 2);
      if (hpos !== 8'(c % 228) || cpu_ce !== exp_t || riot_ce !== exp_t ||
          rdy !== 1'b1 || line_start !== (c % 228 == 0)) errs++;
      if (c < 228 && cpu_ce === 1'b1) ncpu++;
      if (line_start === 1'b1) nls++;
      step();
    end
    check("cadence_errs", errs, 0);
    check("cpu_per_line", ncpu, 76);
    check("line_starts", nls, 2);

    // ---- WSYNC mid-line ----
    do_reset();
    adv_to(20);
    #2;
    check("ws_cpu_at20", cpu_ce, 1);
    wsync_wr = 1'b1;
    step(); k++;
    errs = 0;
    while (k < 228) begin
      wsync_wr = (k == 23);  // riot tick while halted, must be ignored
      #2;
      exp_t = (k % 3 == 2);
      if (rdy !== 1'b0 || cpu_ce !== 1'b0 || riot_ce !== exp_t || hpos !== 8'(k)) errs++;
      step(); k++;
    end
    wsync_wr = 1'b0;
    check("ws_halt_errs", errs, 0);
    #2;
    check("ws_rdy_h0", rdy, 1);
    check("ws_hpos_h0", hpos, 0);
    check("ws_cpu_h0", cpu_ce, 0);
    step(); k++;
    step(); k++;
    #2;
    check("ws_first_cpu", cpu_ce, 1);
    check("ws_first_hpos", hpos, 2);

    // ---- WSYNC ignored without cpu_ce, and set at the line end ----
    do_reset();
    adv_to(21);
    wsync_wr = 1'b1;
    step(); k++;
    wsync_wr = 1'b0;
    #2;
    check("ign_rdy", rdy, 1);
    step(); k++;
    #2;
    check("ign_cpu23", cpu_ce, 1);
    adv_to(227);
    #2;
    check("edge_cpu227", cpu_ce, 1);
    wsync_wr = 1'b1;
    step(); k++;
    wsync_wr = 1'b0;
    errs = 0;
    while (k < 456) begin
      #2;
      if (rdy !== 1'b0 || cpu_ce !== 1'b0 || hpos !== 8'(k - 228)) errs++;
      step(); k++;
    end
    check("edge_halt_errs", errs, 0);
    #2;
    check("edge_rdy_rel", rdy, 1);
    check("edge_hpos_rel", hpos, 0);
    step(); k++;
    step(); k++;
    #2;
    check("edge_first_cpu", cpu_ce, 1);

    // ---- memory stall of 4 cycles at hpos 5 ----
    do_reset();
    adv_to(5);
    mem_busy = 1'b1;
    adv_to(9);
    mem_busy = 1'b0;
    #2;
    check("stall_cpu9", cpu_ce, 1);
    check("stall_hpos9", hpos, 9);
    check("stall_cnt", stall_cycles, 4);
    step(); k++;
    errs = 0;
    while (k < 31) begin
      #2;
      exp_t = (k % 3 == 0);
      if (cpu_ce !== exp_t || riot_ce !== exp_t || hpos !== 8'(k)) errs++;
      step(); k++;
    end
    check("stall_shift_errs", errs, 0);
    check("stall_cnt_hold", stall_cycles, 4);

    // ---- saturation on the 4-bit instance ----
    do_reset();
    adv_to(2);
    mem_busy = 1'b1;
    errs = 0;
    for (int j = 0; j < 20; j++) begin
      #2;
      if (riot_ce2 !== 1'b0 || cpu_ce2 !== 1'b0 || stall_cycles2 !== 4'((j > 15) ? 15 : j)) errs++;
      step(); k++;
    end
    mem_busy = 1'b0;
    check("sat_hold_errs", errs, 0);
    #2;
    check("sat_riot_after", riot_ce2, 1);
    check("sat_cnt", stall_cycles2, 15);
    check("sat_wide_cnt", stall_cycles, 20);
    check("sat_hpos", hpos2, 22);
    step(); k++;
    #2;
    check("sat_riot_next", riot_ce2, 0);
    check("sat_cnt_stick", stall_cycles2, 15);

    // ---- reset during HALT with a stall on record ----
    do_reset();
    adv_to(20);
    wsync_wr = 1'b1;
    step(); k++;
    wsync_wr = 1'b0;
    adv_to(50);
    mem_busy = 1'b1;
    adv_to(53);
    mem_busy = 1'b0;
    adv_to(100);
    #2;
    check("rh_rdy_before", rdy, 0);
    check("rh_hpos_before", hpos, 100);
    check("rh_stall_before", stall_cycles, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("rh_rdy", rdy, 1);
    check("rh_hpos", hpos, 0);
    check("rh_stall", stall_cycles, 0);
    check("rh_ls", line_start, 1);
    check("rh_cpu0", cpu_ce, 0);
    step();
    #2;
    check("rh_cpu1", cpu_ce, 0);
    step();
    #2;
    check("rh_cpu2", cpu_ce, 1);
    check("rh_hpos2", hpos, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/atari_cpu_scheduler.md
# atari_cpu_scheduler

Clock-enable scheduler for the Atari 2600 core: it divides the color clock into CPU/RIOT ticks and implements the TIA WSYNC halt by holding the 6507's RDY low until the end of the current scanline. It also stretches ticks while the external program memory interface reports busy. It sits between the top-level pins/memory interface and the CPU, TIA and RIOT instances, and is the only source of their clock enables.

## Interface
Parameters:
- LINE_CLOCKS, 228: color clocks per scanline; hpos wraps LINE_CLOCKS-1 -> 0.
- CPU_DIV, 3: color clocks per CPU/RIOT tick (minimum, without stalls).
- STALL_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  color clock; everything is in this single clock domain.
- rst  in  1  synchronous, active-high reset.
- mem_busy  in  1  external memory not ready; defers the pending tick.
- wsync_wr  in  1  CPU write to the TIA WSYNC address; only sampled when cpu_ce=1.
- cpu_ce  out  1  6507 clock enable, one-cycle pulse.
- riot_ce  out  1  RIOT clock enable, one-cycle pulse.
- rdy  out  1  6507 RDY; low = CPU halted by WSYNC.
- hpos  out  8  horizontal color-clock position, 0..LINE_CLOCKS-1.
- line_start  out  1  high during the cycle in which hpos==0.
- stall_cycles  out  STALL_W  saturating count of memory-stall cycles.

## Operation
- Registers: hpos, phase (0..CPU_DIV-1), rdy, stall_cycles.
- hpos increments every clk and never stalls; at LINE_CLOCKS-1 it wraps to 0.
- tick = (phase==CPU_DIV-1) && !mem_busy.
- phase update: if phase<CPU_DIV-1, phase+1. If phase==CPU_DIV-1 and mem_busy, hold. If phase==CPU_DIV-1 and !mem_busy, go to 0.
- riot_ce = tick. The RIOT keeps running during WSYNC halts.
- cpu_ce = tick && rdy.
- Outputs cpu_ce and riot_ce are combinational from registered phase/rdy and the mem_busy input. There is no registered delay.
- WSYNC state machine, two states:
  - RUN (rdy=1): if cpu_ce && wsync_wr, go to HALT (rdy=0 from next cycle).
  - HALT (rdy=0): at the edge where hpos==LINE_CLOCKS-1, go to RUN. rdy=1 in the cycle hpos==0.
- wsync_wr while cpu_ce=0 is ignored, including all cycles in HALT.
- Simultaneous set and release: cpu_ce && wsync_wr at the hpos==LINE_CLOCKS-1 edge gives HALT. The set wins, so the CPU halts until the end of the following line.
- stall_cycles increments on every cycle with phase==CPU_DIV-1 && mem_busy. It saturates at all-ones and is cleared only by rst.
- Phase is not resynchronised to hpos. After stalls, tick alignment to hpos shifts permanently by the stall length.

## Timing
- Reset values: hpos=0, phase=0, rdy=1, stall_cycles=0, line_start=1, cpu_ce=0, riot_ce=0.
- rst asserted mid-operation, including during HALT or a stall: all registers return to reset values on that edge. No pending WSYNC survives.
- First tick: cycle 2 after rst deasserts (cycle 0 is the first edge with rst=0). hpos==2 at that tick.
- Unstalled cadence: a tick every CPU_DIV cycles, giving 76 ticks per 228-clock line.
- WSYNC latency: rdy falls 1 cycle after the cpu_ce/wsync_wr cycle. rdy rises in the hpos==0 cycle. The first cpu_ce after release is the next natural tick.
- mem_busy held N cycles at the tick phase delays that tick by exactly N cycles. It adds N to stall_cycles.
- mem_busy in non-tick phases has no effect.

## Test plan
- Reset/cadence: release rst, no stimulus -> cpu_ce and riot_ce at hpos 2,5,...,227; 76 pulses per line; line_start once per 228 cycles; rdy=1.
- WSYNC mid-line: wsync_wr with cpu_ce at hpos 20 -> rdy=0 for hpos 21..227; riot_ce continues at 23,26,...; no cpu_ce until hpos 2 of the next line; rdy=1 at hpos 0.
- WSYNC ignored / edge case: wsync_wr pulsed at hpos 21 (cpu_ce=0) -> no halt. wsync_wr with cpu_ce at hpos 227 -> rdy=0 from hpos 0 through the next line's 227; released at the following hpos 0.
- Memory stall: mem_busy=1 for 4 cycles from hpos 5 -> tick occurs at hpos 9; subsequent ticks at 12,15,...; stall_cycles=4; hpos unaffected.
- Saturation: STALL_W=4, mem_busy held 20 cycles at the tick phase -> stall_cycles sticks at 15; one tick follows when mem_busy drops.
- Reset mid-HALT: assert rst at hpos 100 while rdy=0 -> next cycle rdy=1, hpos=0, phase=0, stall_cycles=0; first cpu_ce 2 cycles after rst deasserts.
